// File: rtl/efpga_cfg_loader_if.sv
// Host-side configuration stream for efpga_cfg_loader.
// A 32-bit valid/ready channel. A beat transfers on cfg_valid && cfg_ready.
interface efpga_cfg_loader_if;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] cfg_data;

    // Host (DMA/FIFO) side
    modport master (output cfg_valid, output cfg_data, input cfg_ready);
    // Loader side
    modport slave  (input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/efpga_cfg_loader.sv
// efpga_cfg_loader: eFPGA configuration sequencer.
// Accepts a framed bitstream (header, N payload words and, optionally, an XOR
// checksum word). Each payload word is pushed to the fabric chains selected by
// the header mask. fabric_en is raised only after a complete, well-formed frame.
// Optional feature macro: EFPGA_CFG_CHECKSUM_EN adds the trailing checksum
// word, the CHECK state and the 32-bit XOR accumulator.
module efpga_cfg_loader #(
    parameter int N_CHAINS = 5,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 res,
    efpga_cfg_loader_if.slave    cfg,
    output logic [31:0]          prog_i,
    output logic [N_CHAINS-1:0]  prog_shft,
    output logic                 fabric_en,
    output logic                 busy,
    output logic                 err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DONE  = 2'd2
`ifdef EFPGA_CFG_CHECKSUM_EN
        , CHECK = 2'd3
`endif
    } state_t;

    state_t              state_reg, state_next;
    logic [N_CHAINS-1:0] mask_reg, mask_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [31:0]         prog_i_reg, prog_i_next;
    logic [N_CHAINS-1:0] shft_reg, shft_next;
    logic                err_reg, err_next;
    logic                ready_reg;
`ifdef EFPGA_CFG_CHECKSUM_EN
    logic [31:0]         acc_reg, acc_next;
`endif

    logic       accept;
    logic       hdr_ok;
    logic [4:0] hdr_mask;

    assign accept   = cfg.cfg_valid && ready_reg;
    assign hdr_mask = cfg.cfg_data[20:16];
    assign hdr_ok   = (cfg.cfg_data[31:24] == 8'hA5) && (hdr_mask != 5'd0) &&
                      (cfg.cfg_data[15:0] != 16'd0);

    // Next-state and datapath decode; every state takes one beat per cycle.
    always_comb begin
        state_next  = state_reg;
        mask_next   = mask_reg;
        cnt_next    = cnt_reg;
        prog_i_next = prog_i_reg;
        shft_next   = '0;
        err_next    = err_reg;
`ifdef EFPGA_CFG_CHECKSUM_EN
        acc_next    = acc_reg;
`endif
        case (state_reg)
            // IDLE and DONE both treat the next beat as a header; DONE just
            // keeps fabric_en up on a bad header.
            IDLE, DONE: begin
                if (accept) begin
                    if (hdr_ok) begin
                        mask_next  = N_CHAINS'(hdr_mask);
                        cnt_next   = CNT_W'(cfg.cfg_data[15:0]);
                        err_next   = 1'b0;
                        state_next = LOAD;
`ifdef EFPGA_CFG_CHECKSUM_EN
                        acc_next   = '0;
`endif
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (accept) begin
                    prog_i_next = cfg.cfg_data;
                    shft_next   = mask_reg;
                    cnt_next    = cnt_reg - CNT_W'(1);
`ifdef EFPGA_CFG_CHECKSUM_EN
                    acc_next    = acc_reg ^ cfg.cfg_data;
`endif
                    // Counter is loaded with N (non-zero), so the last word is
                    // seen at 1 and it never wraps inside a frame.
                    if (cnt_reg == CNT_W'(1)) begin
`ifdef EFPGA_CFG_CHECKSUM_EN
                        state_next = CHECK;
`else
                        state_next = DONE;
`endif
                    end
                end
            end
`ifdef EFPGA_CFG_CHECKSUM_EN
            CHECK: begin
                if (accept) begin
                    if (cfg.cfg_data == acc_reg) begin
                        state_next = DONE;
                    end else begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // State and output registers; ready is held low for the cycle after reset.
    always_ff @(posedge clk) begin
        if (res) begin
            state_reg  <= IDLE;
            mask_reg   <= '0;
            cnt_reg    <= '0;
            prog_i_reg <= '0;
            shft_reg   <= '0;
            err_reg    <= 1'b0;
            ready_reg  <= 1'b0;
`ifdef EFPGA_CFG_CHECKSUM_EN
            acc_reg    <= '0;
`endif
        end else begin
            state_reg  <= state_next;
            mask_reg   <= mask_next;
            cnt_reg    <= cnt_next;
            prog_i_reg <= prog_i_next;
            shft_reg   <= shft_next;
            err_reg    <= err_next;
            ready_reg  <= 1'b1;
`ifdef EFPGA_CFG_CHECKSUM_EN
            acc_reg    <= acc_next;
`endif
        end
    end

    assign cfg.cfg_ready = ready_reg;
    assign prog_i        = prog_i_reg;
    assign prog_shft     = shft_reg;
    assign err           = err_reg;
    assign fabric_en     = (state_reg == DONE);
`ifdef EFPGA_CFG_CHECKSUM_EN
    assign busy          = (state_reg == LOAD) || (state_reg == CHECK);
`else
    assign busy          = (state_reg == LOAD);
`endif

endmodule

// File: tb/tb_efpga_cfg_loader.sv
// Testbench for efpga_cfg_loader: directed frames followed by randomized
// frames, every cycle compared against a frame-level reference model.
module tb_efpga_cfg_loader;
    localparam int NC = 5;
`ifdef EFPGA_CFG_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic clk = 1'b0;
    logic res;
    always #5 clk = ~clk;

    efpga_cfg_loader_if cfg ();
    logic [31:0]   prog_i;
    logic [NC-1:0] prog_shft;
    logic          fabric_en, busy, err;

    efpga_cfg_loader #(.N_CHAINS(NC), .CNT_W(16)) dut (
        .clk       (clk),
        .res       (res),
        .cfg       (cfg),
        .prog_i    (prog_i),
        .prog_shft (prog_shft),
        .fabric_en (fabric_en),
        .busy      (busy),
        .err       (err)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: frame-level bookkeeping
    bit          m_ready = 1'b0;
    int          m_rem   = 0;      // payload words still expected
    bit          m_ckpend = 1'b0;  // checksum word expected next
    bit          m_en = 1'b0, m_err = 1'b0;
    logic [31:0] m_xor = '0, m_pi = '0;
    logic [4:0]  m_mask = '0, m_sh = '0;
    int          pulses = 0;

    logic [31:0] beats[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Apply the effect of one clock edge to the model.
    task automatic model_edge(input bit r, input bit v, input logic [31:0] d);
        m_sh = '0;
        if (r) begin
            m_ready = 0; m_rem = 0; m_ckpend = 0; m_en = 0; m_err = 0;
            m_xor = '0; m_pi = '0; m_mask = '0;
            return;
        end
        if (v && m_ready) begin
            if (m_rem > 0) begin
                m_pi = d; m_sh = m_mask; m_xor ^= d; m_rem--; pulses++;
                if (m_rem == 0) begin
                    if (CK) m_ckpend = 1;
                    else    m_en = 1;
                end
            end else if (m_ckpend) begin
                m_ckpend = 0;
                if (d == m_xor) m_en = 1;
                else            m_err = 1;
            end else if (d[31:24] == 8'hA5 && d[20:16] != 0 && d[15:0] != 0) begin
                m_mask = d[20:16]; m_rem = int'(d[15:0]); m_xor = '0;
                m_err = 0; m_en = 0;
            end else begin
                m_err = 1;
            end
        end
        m_ready = 1;
    endtask

    // One clock: drive inputs, advance the model, compare all outputs.
    task automatic cycle(input bit r, input bit v, input logic [31:0] d);
        res = r; cfg.cfg_valid = v; cfg.cfg_data = d;
        @(posedge clk);
        model_edge(r, v, d);
        #1;
        check_val("prog_i",    prog_i,              m_pi);
        check_val("prog_shft", 32'(prog_shft),      32'(m_sh[NC-1:0]));
        check_val("fabric_en", 32'(fabric_en),      32'(m_en));
        check_val("busy",      32'(busy),           32'((m_rem > 0) || m_ckpend));
        check_val("err",       32'(err),            32'(m_err));
        check_val("cfg_ready", 32'(cfg.cfg_ready),  32'(m_ready));
    endtask

    // Send the queued beats with up to max_gap idle cycles before each;
    // optionally pulse reset right after beat index rst_at.
    task automatic run_beats(input string name, input int max_gap, input int rst_at);
        int p0 = pulses;
        for (int i = 0; i < beats.size(); i++) begin
            int g = (max_gap > 0) ? $urandom_range(0, max_gap) : 0;
            for (int k = 0; k < g; k++) cycle(0, 0, $urandom);
            cycle(0, 1, beats[i]);
            if (i == rst_at) cycle(1, $urandom_range(0, 1), $urandom);
        end
        $display("frame %s hdr=%h beats=%0d pulses=%0d fabric_en=%b err=%b",
                 name, beats[0], beats.size(), pulses - p0, fabric_en, err);
    endtask

    initial begin
        logic [31:0] x;
        res = 1'b1; cfg.cfg_valid = 1'b0; cfg.cfg_data = '0;
        cycle(1, 0, '0);
        cycle(1, 0, '0);
        cycle(0, 0, '0);

        // Basic two-word frame on chains 0 and 1
        beats = '{32'hA5030002, 32'h11111111, 32'h22222222};
        if (CK) beats.push_back(32'h33333333);
        run_beats("basic", 0, -1);
        cycle(0, 0, '0);

        // Bad sync byte from IDLE after reset
        cycle(1, 0, '0); cycle(0, 0, '0);
        beats = '{32'h5A010001};
        run_beats("badsync", 0, -1);
        cycle(0, 0, '0);

        // Single word; with checksum this ends in a mismatch
        beats = '{32'hA5040001, 32'hDEADBEEF};
        if (CK) beats.push_back(32'h00000000);
        run_beats("badck", 0, -1);
        cycle(0, 0, '0);

        // All chains with stalls between beats
        cycle(0, 1, 32'hA51F0003);
        cycle(0, 0, $urandom); cycle(0, 0, $urandom);
        cycle(0, 1, 32'h0BADF00D);
        cycle(0, 0, $urandom);
        cycle(0, 1, 32'h12345678);
        cycle(0, 0, $urandom);
        cycle(0, 1, 32'h9ABCDEF0);
        if (CK) cycle(0, 1, 32'h0BADF00D ^ 32'h12345678 ^ 32'h9ABCDEF0);
        $display("frame gaps hdr=A51F0003 fabric_en=%b err=%b", fabric_en, err);

        // Bad header while in DONE, then reprogram from DONE
        beats = '{32'hA5000001};
        run_beats("done_badhdr", 0, -1);
        beats = '{32'hA5020001, 32'hCAFEF00D};
        if (CK) beats.push_back(32'hCAFEF00D);
        run_beats("reprog", 0, -1);
        cycle(0, 0, '0);

        // Reset after the first of four payload words, then a full frame
        beats = '{32'hA5050004, 32'h01020304, 32'h05060708, 32'h090A0B0C, 32'h0D0E0F10};
        run_beats("midreset", 0, 1);
        beats = '{32'hA5070002, 32'hAAAA5555, 32'h5555AAAA};
        if (CK) beats.push_back(32'hFFFFFFFF);
        run_beats("after_reset", 0, -1);

        // Longer frame to exercise the counter
        beats = '{32'hA5090120};
        x = '0;
        for (int i = 0; i < 288; i++) begin
            beats.push_back($urandom);
            x ^= beats[beats.size() - 1];
        end
        if (CK) beats.push_back(x);
        run_beats("long", 1, -1);

        // Randomized frames, including malformed headers and bad checksums
        for (int f = 0; f < 150; f++) begin
            logic [31:0] h;
            int n;
            n = ($urandom_range(0, 11) == 0) ? 0 : $urandom_range(1, 5);
            h = $urandom;
            if ($urandom_range(0, 9) != 0) h[31:24] = 8'hA5;
            if ($urandom_range(0, 9) != 0 && h[20:16] == 0) h[20:16] = 5'd1;
            h[15:0] = 16'(n);
            beats = '{h};
            x = '0;
            for (int i = 0; i < n; i++) begin
                beats.push_back($urandom);
                x ^= beats[beats.size() - 1];
            end
            if (CK) beats.push_back(($urandom_range(0, 4) == 0) ? (x ^ 32'h1) : x);
            run_beats($sformatf("rand%0d", f), $urandom_range(0, 2),
                      ($urandom_range(0, 14) == 0) ? $urandom_range(0, beats.size() - 1) : -1);
        end

        cycle(0, 0, '0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
